// File: rtl/dct_2d_ctrl.sv
// ---------------------------------------------------------------------------
// dct_2d_ctrl : 8x8 two-dimensional forward DCT controller.
//
// A single 8-point integer 1-D DCT is time-shared between a row pass and a
// column pass. Each accepted row is transformed in the cycle it arrives and
// written into an 8x8 transpose buffer. Once row 7 has been stored, the eight
// buffer columns are transformed one per cycle and presented on out_data.
//
// 1-D transform (all arithmetic 16-bit two's complement, wrap on overflow):
//   y[k] = sum_n C[k][n] * x[n], with the integer basis
//     k0:  8   8   8   8   8   8   8   8
//     k1: 12  10   6   3  -3  -6 -10 -12
//     k2:  8   4  -4  -8  -8  -4   4   8
//     k3: 10  -3 -12  -6   6  12   3 -10
//     k4:  8  -8  -8   8   8  -8  -8   8
//     k5:  6 -12   3  10 -10  -3  12  -6
//     k6:  4  -8   8  -4  -4   8  -8   4
//     k7:  3  -6  10 -12  12 -10   6  -3
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   row offered on in_data
//   in_ready   row accepted when in_valid && in_ready on a rising edge
//   in_data    8 unsigned samples, element i at bits [i*INPUT_W +: INPUT_W]
//   out_valid  out_data holds one transformed column
//   out_ready  column consumed when out_valid && out_ready on a rising edge
//   out_data   8 signed 16-bit coefficients, element k at bits [k*16 +: 16]
//   out_col    column index of out_data
//   out_last   high with out_valid on column 7
//
// Build option:
//   DCT_2D_CTRL_LEVEL_SHIFT_EN  when defined, 2^(INPUT_W-1) is subtracted from
//                               every zero-extended input sample (JPEG level
//                               shift). Interface and timing are unchanged.
// ---------------------------------------------------------------------------

// 8-point integer forward DCT, purely combinational, even/odd butterfly form.
module dct_1d8 (
   input  logic [7:0][15:0] x_i,
   output logic [7:0][15:0] y_o
);
   logic signed [15:0] s0, s1, s2, s3;
   logic signed [15:0] d0, d1, d2, d3;
   logic signed [15:0] f0, f1;

   always_comb begin
      s0 = x_i[0] + x_i[7];
      s1 = x_i[1] + x_i[6];
      s2 = x_i[2] + x_i[5];
      s3 = x_i[3] + x_i[4];
      d0 = x_i[0] - x_i[7];
      d1 = x_i[1] - x_i[6];
      d2 = x_i[2] - x_i[5];
      d3 = x_i[3] - x_i[4];
      f0 = s0 - s3;
      f1 = s1 - s2;

      y_o[0] = 16'sd8 * (s0 + s1 + s2 + s3);
      y_o[4] = 16'sd8 * (s0 - s1 - s2 + s3);
      y_o[2] = 16'sd8 * f0 + 16'sd4 * f1;
      y_o[6] = 16'sd4 * f0 - 16'sd8 * f1;
      y_o[1] = 16'sd12 * d0 + 16'sd10 * d1 + 16'sd6  * d2 + 16'sd3  * d3;
      y_o[3] = 16'sd10 * d0 - 16'sd3  * d1 - 16'sd12 * d2 - 16'sd6  * d3;
      y_o[5] = 16'sd6  * d0 - 16'sd12 * d1 + 16'sd3  * d2 + 16'sd10 * d3;
      y_o[7] = 16'sd3  * d0 - 16'sd6  * d1 + 16'sd10 * d2 - 16'sd12 * d3;
   end
endmodule

module dct_2d_ctrl #(
   parameter int INPUT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [8*INPUT_W-1:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*16-1:0]        out_data,
   output logic [2:0]             out_col,
   output logic                   out_last
);
   typedef enum logic {ST_ROW, ST_COL} state_e;

   state_e           state_q;
   logic [2:0]       row_q;
   logic [3:0]       col_q;       // next column to load; 8 means all loaded
   logic             out_valid_q;
   logic [8*16-1:0]  out_data_q;
   logic [2:0]       out_col_q;
   logic             out_last_q;

   logic [15:0]      tbuf_q [8][8];   // [row][col]

   logic [7:0][15:0] dct_in;
   logic [7:0][15:0] dct_out;
   logic             row_acc;
   logic             col_load;
   logic             col_take;

   function automatic logic [15:0] pix_ext(input logic [INPUT_W-1:0] p);
      logic [15:0] z;
      z = 16'(p);
`ifdef DCT_2D_CTRL_LEVEL_SHIFT_EN
      z = z - (16'd1 << (INPUT_W - 1));
`endif
      return z;
   endfunction

   // Shared transform input: incoming row during ROW, buffer column during COL.
   always_comb begin
      dct_in = '0;
      for (int k = 0; k < 8; k++) begin
         if (state_q == ST_ROW)
            dct_in[k] = pix_ext(in_data[k*INPUT_W +: INPUT_W]);
         else
            dct_in[k] = tbuf_q[k][col_q[2:0]];
      end
   end

   dct_1d8 u_dct (
      .x_i (dct_in),
      .y_o (dct_out)
   );

   assign row_acc  = (state_q == ST_ROW) && in_valid;
   assign col_take = out_valid_q && out_ready;
   assign col_load = (state_q == ST_COL) && !col_q[3] && (!out_valid_q || out_ready);

   // Row pass -> transpose buffer boundary (contents survive reset).
   always_ff @(posedge clk) begin
      if (row_acc) begin
         for (int k = 0; k < 8; k++)
            tbuf_q[row_q][k] <= dct_out[k];
      end
   end

   // Column pass -> output register boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ROW;
         row_q       <= 3'd0;
         col_q       <= 4'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_col_q   <= 3'd0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_ROW: begin
               if (row_acc) begin
                  row_q <= row_q + 3'd1;   // wraps to 0 after row 7
                  if (row_q == 3'd7) begin
                     state_q <= ST_COL;
                     col_q   <= 4'd0;
                  end
               end
            end
            ST_COL: begin
               if (col_load) begin
                  out_data_q  <= dct_out;
                  out_col_q   <= col_q[2:0];
                  out_last_q  <= (col_q[2:0] == 3'd7);
                  out_valid_q <= 1'b1;
                  col_q       <= col_q + 4'd1;
               end else if (col_take) begin
                  // Only reachable once column 7 has been loaded.
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  col_q       <= 4'd0;
                  state_q     <= ST_ROW;
               end
            end
            default: state_q <= ST_ROW;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_ROW);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_col   = out_col_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct_2d_ctrl.sv
module tb_dct_2d_ctrl;
   localparam int INPUT_W = 8;

   logic                  clk;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [8*INPUT_W-1:0]  in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [8*16-1:0]       out_data;
   logic [2:0]            out_col;
   logic                  out_last;

   dct_2d_ctrl #(.INPUT_W(INPUT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_col   (out_col),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic fail_now(input string nm);
      total_cnt++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // ---------------- golden 2-D model ----------------
   int C [8][8] = '{
      '{ 8,  8,  8,  8,  8,  8,  8,  8},
      '{12, 10,  6,  3, -3, -6,-10,-12},
      '{ 8,  4, -4, -8, -8, -4,  4,  8},
      '{10, -3,-12, -6,  6, 12,  3,-10},
      '{ 8, -8, -8,  8,  8, -8, -8,  8},
      '{ 6,-12,  3, 10,-10, -3, 12, -6},
      '{ 4, -8,  8, -4, -4,  8, -8,  4},
      '{ 3, -6, 10,-12, 12,-10,  6, -3}};

   int gx [8][8];   // [row][col] input samples
   int gr [8][8];   // [row][k]   row-pass result
   int gy [8][8];   // [col][k]   final column coefficients

   function automatic int w16(input int v);
      logic signed [15:0] t;
      t = v[15:0];
      return int'(t);
   endfunction

   function automatic void compute_golden();
      int acc;
      int shift;
      shift = 0;
`ifdef DCT_2D_CTRL_LEVEL_SHIFT_EN
      shift = 1 << (INPUT_W - 1);
`endif
      for (int r = 0; r < 8; r++)
         for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++) acc += C[k][n] * (gx[r][n] - shift);
            gr[r][k] = w16(acc);
         end
      for (int c = 0; c < 8; c++)
         for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int r = 0; r < 8; r++) acc += C[k][r] * gr[r][c];
            gy[c][k] = w16(acc);
         end
   endfunction

   // ---------------- scoreboard / compare process ----------------
   logic [127:0] exp_data_q [$];
   int           exp_col_q  [$];
   int           rowbuf [8][8];
   int           rows_got = 0;
   bit           started = 0;
   bit           prev_hold = 0;
   logic [127:0] prev_data;
   logic [2:0]   prev_col;
   logic         prev_last;

   int acc0_edge = -1, acc7_edge = -1;
   bit lat_arm = 0;
   int lat_first_valid = -1, lat_col7_hs = -1, lat_rdy_back = -1;

   always @(negedge clk) begin
      if (rst) begin
         exp_data_q.delete();
         exp_col_q.delete();
         rows_got  = 0;
         prev_hold = 0;
      end else if (started) begin
         chk("in_ready", 128'(in_ready), 128'(exp_col_q.size() == 0));
         if (exp_col_q.size() == 0) chk("idle_out_valid", 128'(out_valid), 128'(0));
         if (prev_hold) begin
            chk("hold_valid", 128'(out_valid), 128'(1));
            chk("hold_data", out_data, prev_data);
            chk("hold_col", 128'(out_col), 128'(prev_col));
            chk("hold_last", 128'(out_last), 128'(prev_last));
         end
         if (out_valid) chk("last_vs_col", 128'(out_last), 128'(out_col == 3'd7));
         if (lat_arm && out_valid && lat_first_valid < 0) lat_first_valid = cyc;
         if (lat_arm && in_ready && lat_col7_hs >= 0 && lat_rdy_back < 0) lat_rdy_back = cyc;

         if (out_valid && out_ready) begin
            if (exp_col_q.size() == 0) fail_now("unexpected_column");
            else begin
               chk("col_data", out_data, exp_data_q[0]);
               chk("col_idx", 128'(out_col), 128'(exp_col_q[0]));
               chk("col_last", 128'(out_last), 128'(exp_col_q[0] == 7));
               if (exp_col_q[0] == 7 && lat_arm) lat_col7_hs = cyc + 1;
               void'(exp_data_q.pop_front());
               void'(exp_col_q.pop_front());
            end
         end

         if (in_valid && in_ready) begin
            for (int n = 0; n < 8; n++) rowbuf[rows_got][n] = int'(in_data[n*INPUT_W +: INPUT_W]);
            if (rows_got == 0) acc0_edge = cyc + 1;
            rows_got++;
            if (rows_got == 8) begin
               logic [127:0] e;
               gx = rowbuf;
               compute_golden();
               for (int c = 0; c < 8; c++) begin
                  e = '0;
                  for (int k = 0; k < 8; k++) e[k*16 +: 16] = 16'(gy[c][k]);
                  exp_data_q.push_back(e);
                  exp_col_q.push_back(c);
               end
               acc7_edge = cyc + 1;
               rows_got  = 0;
            end
         end

         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         prev_col  = out_col;
         prev_last = out_last;
      end
   end

   // ---------------- stimulus ----------------
   int  blk [8][8];
   bit  rnd_ordy = 0;

   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_ordy) out_ready = 1'($urandom_range(0, 1));
   end

   function automatic logic [8*INPUT_W-1:0] pack_row(input int r);
      logic [8*INPUT_W-1:0] d;
      for (int n = 0; n < 8; n++) d[n*INPUT_W +: INPUT_W] = INPUT_W'(blk[r][n]);
      return d;
   endfunction

   task automatic fill_ramp();
      for (int r = 0; r < 8; r++) for (int n = 0; n < 8; n++) blk[r][n] = 8 * r + n;
   endtask

   task automatic fill_const(input int v);
      for (int r = 0; r < 8; r++) for (int n = 0; n < 8; n++) blk[r][n] = v;
   endtask

   task automatic fill_rand();
      for (int r = 0; r < 8; r++)
         for (int n = 0; n < 8; n++) blk[r][n] = int'($urandom_range(0, (1 << INPUT_W) - 1));
   endtask

   // mode 0: back-to-back, 1: in_valid toggles 1/0, 2: random gaps
   task automatic send_rows(input int first, input int last, input int mode, output bit ok);
      bit got;
      ok = 1;
      for (int r = first; r <= last; r++) begin
         in_data  = pack_row(r);
         in_valid = 1'b1;
         got = 0;
         for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready) begin got = 1; break; end
         end
         if (!got) begin
            fail_now("row_accept_timeout");
            in_valid = 1'b0;
            ok = 0;
            return;
         end
         @(posedge clk);
         #1;
         if (mode != 0) begin
            int gap;
            gap = (mode == 1) ? 1 : int'($urandom_range(0, 2));
            if (gap > 0) begin
               in_valid = 1'b0;
               in_data  = {$urandom, $urandom};
               repeat (gap) begin @(posedge clk); #1; end
            end
         end
      end
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
   endtask

   task automatic wait_drain();
      bit done;
      done = 0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (exp_col_q.size() == 0 && rows_got == 0) begin done = 1; break; end
      end
      if (!done) fail_now("drain_timeout");
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic hold_col3();
      bit seen;
      seen = 0;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk);
         #1;
         if (out_valid && out_col == 3'd3) begin seen = 1; break; end
      end
      if (!seen) begin fail_now("wait_col3_timeout"); return; end
      out_ready = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("bp_valid", 128'(out_valid), 128'(1));
         chk("bp_col3", 128'(out_col), 128'(3));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", 128'(out_valid), 128'(1));
      chk("bp_release_col4", 128'(out_col), 128'(4));
   endtask

   initial begin
      bit ok;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

      // Hand-computed values pinning the model (identical in both builds,
      // since the level-shift offset times 64 vanishes modulo 2^16 on DC).
      fill_ramp();
      gx = blk;
      compute_golden();
      chk("pin_ramp_row0_k1", 128'(gr[0][1]), 128'(-155));
      chk("pin_ramp_col0_k0", 128'(gy[0][0]), 128'(-2048));
      chk("pin_ramp_col0_k1", 128'(gy[0][1]), 128'(-13824));
      chk("pin_ramp_col1_k0", 128'(gy[1][0]), 128'(-9920));
      fill_const(128);
      gx = blk;
      compute_golden();
`ifdef DCT_2D_CTRL_LEVEL_SHIFT_EN
      chk("pin_const_row_dc", 128'(gr[3][0]), 128'(0));
`else
      chk("pin_const_row_dc", 128'(gr[3][0]), 128'(8192));
`endif
      chk("pin_const_ac", 128'(gy[0][5] | gy[4][0] | gy[7][7]), 128'(0));

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_data", out_data, 128'(0));
      chk("rst_out_col", 128'(out_col), 128'(0));
      chk("rst_out_last", 128'(out_last), 128'(0));
      rst = 1'b0;
      started = 1;
      chk("rst_in_ready", 128'(in_ready), 128'(1));

      // Latency and back-to-back throughput on a ramp block.
      fill_ramp();
      lat_arm = 1;
      send_rows(0, 7, 0, ok);
      wait_drain();
      lat_arm = 0;
      chk("lat_first_valid", 128'(lat_first_valid), 128'(acc7_edge + 1));
      // Column 0 shows after t+1 and is consumed at t+2; column 7 at t+9.
      chk("lat_col7_handshake", 128'(lat_col7_hs), 128'(acc7_edge + 9));
      chk("lat_in_ready_back", 128'(lat_rdy_back), 128'(acc7_edge + 9));

      // Constant block of 128.
      fill_const(128);
      send_rows(0, 7, 0, ok);
      wait_drain();

      // Backpressure on column 3.
      fill_rand();
      send_rows(0, 7, 0, ok);
      hold_col3();
      wait_drain();

      // Reset in the middle of a block, then a ramp block.
      fill_rand();
      send_rows(0, 4, 0, ok);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_out_valid", 128'(out_valid), 128'(0));
      chk("midrst_out_data", out_data, 128'(0));
      chk("midrst_in_ready", 128'(in_ready), 128'(1));
      fill_ramp();
      send_rows(0, 7, 0, ok);
      wait_drain();

      // in_valid toggling during the row pass.
      fill_ramp();
      send_rows(0, 7, 1, ok);
      chk("toggle_span", 128'(acc7_edge - acc0_edge), 128'(14));
      wait_drain();

      // Random blocks with random gaps and random backpressure.
      rnd_ordy = 1;
      for (int b = 0; b < 6; b++) begin
         fill_rand();
         send_rows(0, 7, 2, ok);
      end
      wait_drain();
      rnd_ordy = 0;
      out_ready = 1'b1;
      wait_drain();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
